// File: rtl/bst_bias_update_unit.sv
// Resolve-stage BST classifier, predictor/history write enables and bias weight table.
// Latency: status/enables/bias_update combinational; flush registered (1 cycle); table write seen next cycle.
// Backpressure: none; one resolution accepted every cycle.
module bst_bias_update_unit #(
    parameter int THETA        = 14,
    parameter int BIAS_ENTRIES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        branch_direction,
    input  logic        branch_prediction,
    input  logic [31:0] inst,
    input  logic [31:0] pc_predict,
    input  logic [31:0] pc_actual,
    input  logic [31:0] pc_alu,
    input  logic [1:0]  old_status,
    input  logic [8:0]  total_weights_update,
    input  logic [31:0] pc_fetch,
    input  logic [31:0] pc_update,
    input  logic [1:0]  old_bias,
    output logic [1:0]  bias_weight,
    output logic [1:0]  status_update,
    output logic [31:0] bst_target_update,
    output logic        en_2,
    output logic        en_3,
    output logic        en_2_reg,
    output logic        en_2_reg_bf,
    output logic [1:0]  bias_update,
    output logic        flush
);
    localparam int IDX_W = $clog2(BIAS_ENTRIES);

    localparam logic [1:0] ST_UNSEEN     = 2'b00;
    localparam logic [1:0] ST_TAKEN      = 2'b01;
    localparam logic [1:0] ST_NOT_TAKEN  = 2'b10;
    localparam logic [1:0] ST_NON_BIASED = 2'b11;

    localparam logic [1:0] BIAS_MAX = 2'b01;
    localparam logic [1:0] BIAS_MIN = 2'b10;

    logic [1:0] bias_table [BIAS_ENTRIES];
    logic       is_branch;
    logic       mispredict;
    logic       small_sum;
    logic [9:0] sum_ext;
    logic [9:0] sum_abs;
    logic       unused_bits;

    assign is_branch = (inst[6:0] == 7'b1100011);
    assign mispredict = is_branch & (pc_predict != pc_actual);

    always_comb begin
        status_update = old_status;
        if (is_branch) begin
            unique case (old_status)
                ST_UNSEEN:     status_update = branch_direction ? ST_TAKEN : ST_NOT_TAKEN;
                ST_TAKEN:      status_update = branch_direction ? ST_TAKEN : ST_NON_BIASED;
                ST_NOT_TAKEN:  status_update = branch_direction ? ST_NON_BIASED : ST_NOT_TAKEN;
                ST_NON_BIASED: status_update = ST_NON_BIASED;
            endcase
        end
    end

    // Sign-extend by one bit so |-256| = 256 is representable.
    assign sum_ext   = {total_weights_update[8], total_weights_update};
    assign sum_abs   = sum_ext[9] ? (~sum_ext + 10'd1) : sum_ext;
    assign small_sum = (sum_abs <= 10'(THETA));

    assign en_2        = is_branch;
    assign en_3        = is_branch & (status_update == ST_NON_BIASED)
                         & ((branch_prediction != branch_direction) | small_sum);
    assign en_2_reg    = mispredict & (old_status != ST_UNSEEN);
    assign en_2_reg_bf = mispredict & (old_status == ST_NON_BIASED);
    assign bst_target_update = pc_alu;

    always_comb begin
        bias_update = old_bias;
        if (branch_direction) begin
            if (old_bias != BIAS_MAX) bias_update = old_bias + 2'd1;
        end else begin
            if (old_bias != BIAS_MIN) bias_update = old_bias - 2'd1;
        end
    end

    assign bias_weight = bias_table[pc_fetch[IDX_W:1]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flush <= 1'b0;
            for (int i = 0; i < BIAS_ENTRIES; i++) bias_table[i] <= 2'b00;
        end else begin
            flush <= mispredict;
            if (en_2 | en_3) bias_table[pc_update[IDX_W:1]] <= bias_update;
        end
    end

    assign unused_bits = ^{inst[31:7], pc_fetch[31:IDX_W+1], pc_fetch[0],
                           pc_update[31:IDX_W+1], pc_update[0]};
endmodule

// File: tb/tb_bst_bias_update_unit.sv
// Bench for bst_bias_update_unit: directed vector table, reset/flush sequences,
// and randomized resolutions checked against a set-based status model and an array bias table.
module tb_bst_bias_update_unit;
    logic        clk;
    logic        rst;
    logic        branch_direction;
    logic        branch_prediction;
    logic [31:0] inst;
    logic [31:0] pc_predict;
    logic [31:0] pc_actual;
    logic [31:0] pc_alu;
    logic [1:0]  old_status;
    logic [8:0]  total_weights_update;
    logic [31:0] pc_fetch;
    logic [31:0] pc_update;
    logic [1:0]  old_bias;
    logic [1:0]  bias_weight;
    logic [1:0]  status_update;
    logic [31:0] bst_target_update;
    logic        en_2;
    logic        en_3;
    logic        en_2_reg;
    logic        en_2_reg_bf;
    logic [1:0]  bias_update;
    logic        flush;

    bst_bias_update_unit #(.THETA(14), .BIAS_ENTRIES(1024)) dut (
        .clk(clk), .rst(rst),
        .branch_direction(branch_direction), .branch_prediction(branch_prediction),
        .inst(inst), .pc_predict(pc_predict), .pc_actual(pc_actual), .pc_alu(pc_alu),
        .old_status(old_status), .total_weights_update(total_weights_update),
        .pc_fetch(pc_fetch), .pc_update(pc_update), .old_bias(old_bias),
        .bias_weight(bias_weight), .status_update(status_update),
        .bst_target_update(bst_target_update), .en_2(en_2), .en_3(en_3),
        .en_2_reg(en_2_reg), .en_2_reg_bf(en_2_reg_bf),
        .bias_update(bias_update), .flush(flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [1:0] mtab [1024];
    logic       exp_mis;
    logic       exp_wr;
    logic [1:0] exp_bu;

    typedef struct {
        logic [31:0] inst;
        logic [1:0]  st;
        logic        dir;
        logic        pred;
        logic [31:0] pp;
        logic [31:0] pa;
        logic [8:0]  twu;
        logic [1:0]  ob;
        logic [1:0]  e_su;
        logic        e_en2;
        logic        e_en3;
        logic        e_r;
        logic        e_rbf;
        logic [1:0]  e_bu;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Status as the set of outcomes seen so far: bit0 = taken seen, bit1 = not-taken seen.
    function automatic logic [1:0] m_status(input logic [1:0] old, input logic taken, input logic br);
        if (!br) return old;
        return old | (taken ? 2'b01 : 2'b10);
    endfunction

    function automatic logic [1:0] m_bias(input logic [1:0] ob, input logic taken);
        int v;
        logic [1:0] r;
        v = $signed(ob);
        v = taken ? v + 1 : v - 1;
        if (v > 1) v = 1;
        if (v < -2) v = -2;
        r = 2'(v);
        return r;
    endfunction

    task automatic drive(input logic [31:0] i_inst, input logic [1:0] st, input logic dir,
                         input logic pred, input logic [31:0] pp, input logic [31:0] pa,
                         input logic [8:0] twu, input logic [1:0] ob,
                         input logic [31:0] pf, input logic [31:0] pu);
        @(negedge clk);
        inst = i_inst; old_status = st; branch_direction = dir; branch_prediction = pred;
        pc_predict = pp; pc_actual = pa; total_weights_update = twu; old_bias = ob;
        pc_fetch = pf; pc_update = pu; pc_alu = $urandom;
        #1;
    endtask

    task automatic check_model();
        logic br;
        logic [1:0] su;
        int sum;
        logic e3;
        br  = (inst[6:0] == 7'h63);
        su  = m_status(old_status, branch_direction, br);
        sum = $signed(total_weights_update);
        if (sum < 0) sum = -sum;
        e3  = br && su == 2'b11 && (branch_prediction != branch_direction || sum <= 14);
        exp_mis = br && (pc_predict != pc_actual);
        exp_wr  = br || e3;
        exp_bu  = m_bias(old_bias, branch_direction);
        chk("status_update", 32'(status_update), 32'(su));
        chk("en_2", 32'(en_2), 32'(br));
        chk("en_3", 32'(en_3), 32'(e3));
        chk("en_2_reg", 32'(en_2_reg), 32'(exp_mis && old_status != 2'b00));
        chk("en_2_reg_bf", 32'(en_2_reg_bf), 32'(exp_mis && old_status == 2'b11));
        chk("bias_update", 32'(bias_update), 32'(exp_bu));
        chk("bst_target", bst_target_update, pc_alu);
        chk("bias_weight", 32'(bias_weight), 32'(mtab[pc_fetch[10:1]]));
    endtask

    task automatic tick();
        logic [9:0] idx;
        idx = pc_update[10:1];
        @(posedge clk);
        if (exp_wr) mtab[idx] = exp_bu;
        #1;
        chk("flush", 32'(flush), 32'(exp_mis));
    endtask

    task automatic clear_model();
        for (int i = 0; i < 1024; i++) mtab[i] = 2'b00;
    endtask

    initial begin
        vecs[0]  = '{32'h00000063, 2'b00, 1, 1, 16, 16, 9'd0,   2'b00, 2'b01, 1, 0, 0, 0, 2'b01};
        vecs[1]  = '{32'h00000063, 2'b01, 0, 1, 16, 20, 9'd80,  2'b01, 2'b11, 1, 1, 1, 0, 2'b00};
        vecs[2]  = '{32'h00000063, 2'b11, 1, 1, 16, 16, 9'd100, 2'b00, 2'b11, 1, 0, 0, 0, 2'b01};
        vecs[3]  = '{32'h00000063, 2'b11, 1, 1, 16, 16, 9'h1FB, 2'b00, 2'b11, 1, 1, 0, 0, 2'b01};
        vecs[4]  = '{32'h00000063, 2'b11, 0, 1, 16, 16, 9'd100, 2'b00, 2'b11, 1, 1, 0, 0, 2'b11};
        vecs[5]  = '{32'h00000063, 2'b11, 1, 1, 16, 16, 9'd100, 2'b01, 2'b11, 1, 0, 0, 0, 2'b01};
        vecs[6]  = '{32'h00000063, 2'b10, 0, 0, 16, 16, 9'd100, 2'b10, 2'b10, 1, 0, 0, 0, 2'b10};
        vecs[7]  = '{32'h00000033, 2'b10, 1, 0, 16, 20, 9'd0,   2'b00, 2'b10, 0, 0, 0, 0, 2'b01};
        vecs[8]  = '{32'h00000063, 2'b11, 1, 1, 16, 16, 9'd14,  2'b00, 2'b11, 1, 1, 0, 0, 2'b01};
        vecs[9]  = '{32'h00000063, 2'b11, 1, 1, 16, 16, 9'd15,  2'b00, 2'b11, 1, 0, 0, 0, 2'b01};
        vecs[10] = '{32'h00000063, 2'b11, 0, 0, 16, 16, 9'h1F2, 2'b11, 2'b11, 1, 1, 0, 0, 2'b10};
        vecs[11] = '{32'h00000063, 2'b11, 0, 0, 16, 16, 9'h100, 2'b11, 2'b11, 1, 0, 0, 0, 2'b10};
        vecs[12] = '{32'h00000063, 2'b11, 1, 0, 16, 20, 9'd0,   2'b00, 2'b11, 1, 1, 1, 1, 2'b01};
        vecs[13] = '{32'h00000063, 2'b00, 0, 0, 16, 16, 9'd0,   2'b10, 2'b10, 1, 0, 0, 0, 2'b10};
        vecs[14] = '{32'hABCDE0E3, 2'b10, 1, 1, 16, 16, 9'd0,   2'b01, 2'b11, 1, 1, 0, 0, 2'b01};
        vecs[15] = '{32'hFFFFF033, 2'b01, 0, 1, 16, 20, 9'h1FB, 2'b10, 2'b01, 0, 0, 0, 0, 2'b10};

        clear_model();
        rst = 1'b0;
        inst = '0; old_status = '0; branch_direction = 0; branch_prediction = 0;
        pc_predict = '0; pc_actual = '0; pc_alu = '0; total_weights_update = '0;
        old_bias = '0; pc_fetch = '0; pc_update = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_flush", 32'(flush), 32'd0);
        for (int i = 0; i < 6; i++) begin
            pc_fetch = $urandom;
            #1;
            chk("reset_bias_weight", 32'(bias_weight), 32'd0);
        end
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].inst, vecs[i].st, vecs[i].dir, vecs[i].pred, vecs[i].pp, vecs[i].pa,
                  vecs[i].twu, vecs[i].ob, 32'd16, 32'(16 + 2 * i));
            chk("vec_status_update", 32'(status_update), 32'(vecs[i].e_su));
            chk("vec_en_2", 32'(en_2), 32'(vecs[i].e_en2));
            chk("vec_en_3", 32'(en_3), 32'(vecs[i].e_en3));
            chk("vec_en_2_reg", 32'(en_2_reg), 32'(vecs[i].e_r));
            chk("vec_en_2_reg_bf", 32'(en_2_reg_bf), 32'(vecs[i].e_rbf));
            chk("vec_bias_update", 32'(bias_update), 32'(vecs[i].e_bu));
            check_model();
            tick();
        end
        // Entry written by the first vector (taken from 00) must now read +1.
        drive(32'h0, 2'b00, 0, 0, 0, 0, 0, 0, 32'd16, 32'd0);
        chk("bias_written_16", 32'(bias_weight), 32'd1);
        check_model();
        tick();

        for (int n = 0; n < 400; n++) begin
            logic [31:0] ri;
            logic [31:0] pp;
            ri = $urandom;
            if ($urandom_range(0, 3) != 0) ri[6:0] = 7'h63;
            pp = 32'($urandom_range(0, 7) * 4);
            drive(ri, 2'($urandom), 1'($urandom), 1'($urandom), pp,
                  ($urandom_range(0, 1) != 0) ? pp : pp + 4,
                  ($urandom_range(0, 1) != 0) ? 9'($urandom) : 9'($urandom_range(0, 30) - 15),
                  2'($urandom), 32'($urandom_range(0, 31) * 2), 32'($urandom_range(0, 31) * 2));
            check_model();
            tick();
        end

        // Mispredict raises flush, then an asynchronous reset clears flush and the table at once.
        drive(32'h00000063, 2'b01, 0, 1, 32'd16, 32'd20, 9'd0, 2'b00, 32'd16, 32'd16);
        check_model();
        tick();
        #2;
        rst = 1'b0;
        #1;
        chk("midrun_reset_flush", 32'(flush), 32'd0);
        pc_fetch = 32'd16;
        #1;
        chk("midrun_reset_bias", 32'(bias_weight), 32'd0);
        clear_model();
        @(negedge clk);
        rst = 1'b1;
        drive(32'h00000063, 2'b10, 1, 1, 32'd8, 32'd8, 9'd3, 2'b01, 32'd8, 32'd8);
        check_model();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/bst_bias_update_unit.md
Name: bst_bias_update_unit

Overview:
Resolve-stage update logic for the bias-free neural branch predictor. It classifies each resolved conditional branch in the branch status table (BST), decides which predictor tables and history registers are written, and raises the pipeline flush. It also owns the 1024-entry bias weight table (combinational read at fetch, saturating write at resolve). It sits between the execute-stage resolution signals and the BST, perceptron and bias tables.

Parameters:
THETA, 14, perceptron training threshold applied to |total_weights_update|
BIAS_ENTRIES, 1024, bias table depth, indexed by PC bits [10:1]

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  asynchronous, active-low reset
branch_direction  in  1  resolved outcome (1 = taken)
branch_prediction  in  1  prediction made at fetch for this instruction
inst  in  32  resolved instruction word
pc_predict  in  32  next PC predicted at fetch
pc_actual  in  32  true next PC
pc_alu  in  32  computed branch target
old_status  in  2  BST status read at fetch for this instruction
total_weights_update  in  9  signed perceptron sum computed at fetch
pc_fetch  in  32  fetch PC; bias read index = pc_fetch[10:1]
pc_update  in  32  resolved PC; bias write index = pc_update[10:1]
old_bias  in  2  bias weight read at fetch for this instruction (signed)
bias_weight  out  2  bias_table[pc_fetch[10:1]], combinational
status_update  out  2  new BST status
bst_target_update  out  32  target to store in BST, equals pc_alu
en_2  out  1  BST / conventional-perceptron write enable
en_3  out  1  bias-free perceptron write enable
en_2_reg  out  1  restore conventional history registers
en_2_reg_bf  out  1  restore bias-free history registers
bias_update  out  2  new bias value written to the table
flush  out  1  registered pipeline flush

Behaviour:
- is_branch = (inst[6:0] == 7'b1100011). Example: 0x00000063 is a branch; 0x00000033 is not.
- Status encoding: 00 = unseen, 01 = always taken, 10 = always not-taken, 11 = non-biased.
- status_update (combinational):
  - From 00: 01 if taken, else 10.
  - From 01: not-taken gives 11, otherwise stays 01.
  - From 10: taken gives 11, otherwise stays 10.
  - From 11: stays 11.
  - When is_branch = 0: status_update = old_status.
- en_2 = is_branch.
- mispredict = is_branch & (pc_predict != pc_actual).
- en_3 = is_branch & (status_update == 11) & ((branch_prediction != branch_direction) | |total_weights_update| <= THETA).
  - total_weights_update is two's complement.
  - |-256| is treated as 256.
- en_2_reg = mispredict & (old_status != 00).
- en_2_reg_bf = mispredict & (old_status == 11).
- bias_update = saturating increment of old_bias if taken, decrement if not-taken. Signed range -2..+1: +1 stays +1 on taken, -2 stays -2 on not-taken.
- Bias table write: on a clk rising edge when (en_2 | en_3), bias_table[pc_update[10:1]] <= bias_update.
- Bias table read is combinational. A same-cycle read of the written index returns the old value until the edge.
- flush: register loaded with mispredict every rising edge, so it is high for exactly one cycle after the mispredicting resolution.
- Reset (rst = 0, asynchronous):
  - flush = 0.
  - All bias table entries = 00.
  - Combinational outputs follow their inputs during reset.
- All enables are 0 for non-branch instructions regardless of the other inputs.

Test Plan:
- Reset, then read any pc_fetch -> bias_weight = 00; flush = 0.
- inst = 0x63, old_status = 00, taken, pc_predict = pc_actual = 16, pc_update = 16, old_bias = 00 -> status_update = 01, en_2 = 1, en_3 = 0, bias_update = 01; next cycle bias_weight at pc_fetch = 16 reads 01, flush stays 0.
- inst = 0x63, old_status = 01, not-taken, pc_predict = 16, pc_actual = 20 -> status_update = 11, en_2_reg = 1, en_2_reg_bf = 0, flush = 1 for one cycle.
- inst = 0x63, old_status = 11, prediction correct, total_weights_update = 9'd100 -> en_3 = 0; with total_weights_update = -5 -> en_3 = 1; with a wrong prediction -> en_3 = 1.
- Saturation: old_bias = 01 with taken -> bias_update = 01; old_bias = 10 with not-taken -> bias_update = 10.
- inst = 0x33 with pc_predict != pc_actual -> en_2 = en_3 = en_2_reg = en_2_reg_bf = 0, status_update = old_status, table unchanged, flush stays 0; assert rst mid-run -> flush clears immediately.
